// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op-mode encoding and
// the operand/slice width legality check.
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic logic width_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_ripple_chunk.sv
// One CHUNK-bit combinational ripple slice; also exposes the carry into its
// top bit so the final slice can form signed overflow.
module ripple_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);

  always_comb begin
    logic [W:0] cy;
    cy    = '0;
    sum   = '0;
    cy[0] = c_in;
    for (int i = 0; i < W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
    c_out = cy[W];
    c_msb = cy[W-1];
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor resolving one CHUNK-bit slice per
// stage, with valid/ready handshake and a single global stall.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_valid,
  output logic             out_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_ovf,
  output logic             out_zero
);

  // An illegal WIDTH/CHUNK pair collapses STAGES to 0 and fails elaboration.
  localparam int STAGES  = width_ok(WIDTH, CHUNK) ? WIDTH / CHUNK : 0;
  localparam int OP_BITS = CHUNK * STAGES * (STAGES - 1) / 2;
  localparam int OP_W    = (OP_BITS > 0) ? OP_BITS : 1;
  localparam int SUM_W   = CHUNK * STAGES * (STAGES + 1) / 2;

  // Stage k keeps the not-yet-added operand bits (WIDTH-CHUNK*(k+1)) and the
  // low result bits resolved so far (CHUNK*(k+1)); both are packed flat here.
  function automatic int op_off(input int idx);
    return CHUNK * (idx * (STAGES - 1) - (idx * (idx - 1)) / 2);
  endfunction

  function automatic int sum_off(input int idx);
    return CHUNK * ((idx * (idx + 1)) / 2);
  endfunction

  logic              advance;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] sub_q;
  logic [SUM_W-1:0]  sum_q;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              ovf_q;

  assign advance   = !out_valid || in_ready;
  assign out_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW      = WIDTH - CHUNK * k;
    localparam int SOFF    = sum_off(k);
    localparam int SOFF_IN = (k > 0) ? sum_off(k - 1) : 0;
    localparam int AOFF    = op_off(k);
    localparam int AOFF_IN = (k > 0) ? op_off(k - 1) : 0;

    logic [IW-1:0]          a_in;
    logic [IW-1:0]          b_in;
    logic                   c_in;
    logic                   sub_in;
    logic                   v_in;
    logic [CHUNK-1:0]       s_slice;
    logic                   c_out;
    logic                   c_msb;
    logic [CHUNK*(k+1)-1:0] sum_next;

    if (k == 0) begin : g_head
      // Subtraction is folded into the operands here: A + ~B + ~borrow_in.
      assign a_in     = in_a;
      assign b_in     = (in_sub == SUB) ? ~in_b : in_b;
      assign c_in     = (in_sub == SUB) ? ~in_c : in_c;
      assign sub_in   = in_sub;
      assign v_in     = in_valid;
      assign sum_next = s_slice;
    end else begin : g_body
      assign a_in     = a_q[AOFF_IN +: IW];
      assign b_in     = b_q[AOFF_IN +: IW];
      assign c_in     = c_q[k-1];
      assign sub_in   = sub_q[k-1];
      assign v_in     = v_q[k-1];
      assign sum_next = {s_slice, sum_q[SOFF_IN +: CHUNK*k]};
    end

    ripple_chunk #(.W(CHUNK)) u_chunk (
      .a     (a_in[CHUNK-1:0]),
      .b     (b_in[CHUNK-1:0]),
      .c_in  (c_in),
      .sum   (s_slice),
      .c_out (c_out),
      .c_msb (c_msb)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
        v_q[k]                     <= 1'b0;
        c_q[k]                     <= 1'b0;
        sub_q[k]                   <= ADD;
        sum_q[SOFF +: CHUNK*(k+1)] <= '0;
      end else if (advance) begin
        v_q[k]                     <= v_in;
        c_q[k]                     <= c_out;
        sub_q[k]                   <= sub_in;
        sum_q[SOFF +: CHUNK*(k+1)] <= sum_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic c_msb_unused;
      assign c_msb_unused = c_msb;

      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          a_q[AOFF +: IW-CHUNK] <= '0;
          b_q[AOFF +: IW-CHUNK] <= '0;
        end else if (advance) begin
          a_q[AOFF +: IW-CHUNK] <= a_in[IW-1:CHUNK];
          b_q[AOFF +: IW-CHUNK] <= b_in[IW-1:CHUNK];
        end
      end
    end else begin : g_tail
      // Overflow uses the raw carries, before any borrow inversion.
      always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ c_out;
        end
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = sum_q[sum_off(STAGES-1) +: WIDTH];
  assign out_c     = c_q[STAGES-1] ^ (sub_q[STAGES-1] == SUB);
  assign out_ovf   = ovf_q;
  assign out_zero  = out_valid && (out_sum == '0);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=16, CHUNK=4, latency 4)
// using an arithmetic reference model and an in-order expected queue.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_c;
  logic        in_sub;
  logic        out_valid;
  logic        in_ready;
  logic [15:0] out_sum;
  logic        out_c;
  logic        out_ovf;
  logic        out_zero;
  res_t        obs;

  int   total = 0;
  int   bad   = 0;
  res_t q[$];

  always #5 clk = ~clk;

  assign obs = {out_sum, out_c, out_ovf, out_zero};

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .in_clk    (clk),
    .in_rst_n  (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_c     (out_c),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic sub);
    res_t m;
    int   u;
    int   r;
    if (sub == 1'b0) begin
      u   = int'(a) + int'(b) + int'(c);
      r   = int'($signed(a)) + int'($signed(b)) + int'(c);
      m.c = (u > 65535);
    end else begin
      u   = int'(a) - int'(b) - int'(c);
      r   = int'($signed(a)) - int'($signed(b)) - int'(c);
      m.c = (u < 0);
    end
    m.sum  = u[15:0];
    m.ovf  = (r > 32767) || (r < -32768);
    m.zero = (m.sum == 16'h0000);
    return m;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called just after a falling edge; records the beat if it will be taken.
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, input logic r);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_sub   = s;
    in_ready = r;
    #1;
    if (v && out_ready) q.push_back(model(a, b, c, s));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_in_valid got=%b want=0", out_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++;
    if (out_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h want=0000", out_sum); end
    total++;
    if (out_c !== 1'b0) begin bad++; $display("FAIL reset_c got=%b want=0", out_c); end
    total++;
    if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", out_ovf); end
    total++;
    if (out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", out_zero); end
    total++;
    if (out_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", out_ready); end
    q.delete();
  endtask

  task automatic test_directed();
    logic [15:0] da[4]  = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] db[4]  = '{16'h0001, 16'h0001, 16'h0007, 16'h0001};
    logic        dc[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        ds[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
    res_t        dexp[4];
    dexp[0] = {16'h0000, 1'b1, 1'b0, 1'b1};
    dexp[1] = {16'h8000, 1'b0, 1'b1, 1'b0};
    dexp[2] = {16'hFFFE, 1'b1, 1'b0, 1'b0};
    dexp[3] = {16'h7FFE, 1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      drive(1'b1, da[v], db[v], dc[v], ds[v], 1'b1);
      for (int e = 1; e <= 4; e++) begin
        @(negedge clk);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        if (e == 3) begin
          total++;
          if (out_valid !== 1'b0) begin
            bad++; $display("FAIL dir%0d_early got=%b want=0", v, out_valid);
          end
        end
        if (e == 4) begin
          total++;
          if (out_valid !== 1'b1 || obs !== dexp[v]) begin
            bad++;
            $display("FAIL dir%0d_result got=v%b %h want=v1 %h", v, out_valid, obs, dexp[v]);
          end
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba[6];
    logic [15:0] bb[6];
    logic        bc[6];
    logic        bs[6];
    res_t        bexp[6];
    res_t        snap;
    int          idx = 0;
    int          got = 0;
    int          cyc = 0;
    int          stall_left = 0;
    bit          seen = 0;
    bit          stalling;
    int          extra = 0;
    int          j;
    for (int i = 0; i < 6; i++) begin
      ba[i] = pick(); bb[i] = pick();
      bc[i] = 1'($urandom); bs[i] = 1'($urandom);
      bexp[i] = model(ba[i], bb[i], bc[i], bs[i]);
    end
    snap = '0;
    while (got < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !seen) begin
        seen = 1; stall_left = 3; snap = obs;
      end
      stalling = (stall_left > 0);
      j = (idx < 6) ? idx : 0;
      drive(idx < 6, ba[j], bb[j], bc[j], bs[j], !stalling);
      if (stalling) begin
        stall_left--;
        total++;
        if (out_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", out_ready); end
        total++;
        if (out_valid !== 1'b1 || obs !== snap) begin
          bad++; $display("FAIL stall_hold got=v%b %h want=v1 %h", out_valid, obs, snap);
        end
      end
      if (out_valid && in_ready) begin
        total++;
        if (obs !== bexp[got]) begin
          bad++; $display("FAIL b2b_beat%0d got=%h want=%h", got, obs, bexp[got]);
        end
        got++;
      end
      if (in_valid && out_ready) idx++;
    end
    total++;
    if (got != 6 || idx != 6) begin
      bad++; $display("FAIL b2b_count got=%0d/%0d want=6/6", got, idx);
    end
    repeat (6) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (out_valid) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL b2b_dup got=%0d want=0", extra); end
    q.delete();
  endtask

  task automatic test_random();
    bit          have = 0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        c = 1'b0;
    logic        s = 1'b0;
    logic        r;
    bit          prev_v = 0;
    bit          prev_r = 1;
    res_t        prev_obs = '0;
    bit          hold_chk;
    res_t        e;
    int          drain = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      if (!have) begin
        have = ($urandom_range(0, 9) < 7);
        a = pick(); b = pick(); c = 1'($urandom); s = 1'($urandom);
      end
      r = ($urandom_range(0, 9) < 7);
      hold_chk = prev_v && !prev_r;
      drive(have, a, b, c, s, r);
      total++;
      if (out_ready !== (!out_valid || in_ready)) begin
        bad++; $display("FAIL rnd_ready got=%b want=%b", out_ready, !out_valid || in_ready);
      end
      if (hold_chk) begin
        total++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          bad++; $display("FAIL rnd_hold got=v%b %h want=v1 %h", out_valid, obs, prev_obs);
        end
      end
      if (out_valid && in_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious got=%h want=none", obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin bad++; $display("FAIL rnd_result got=%h want=%h", obs, e); end
        end
      end
      if (have && out_ready) have = 0;
      prev_v = out_valid; prev_r = in_ready; prev_obs = obs;
    end
    while (q.size() > 0 && drain < 30) begin
      @(negedge clk);
      drain++;
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (out_valid) begin
        e = q.pop_front();
        total++;
        if (obs !== e) begin bad++; $display("FAIL rnd_drain got=%h want=%h", obs, e); end
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0", q.size()); end
    q.delete();
  endtask

  task automatic test_mid_reset();
    int   stale = 0;
    res_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, pick(), pick(), 1'($urandom), 1'($urandom), 1'b1);
    end
    @(posedge clk);
    #2;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL mrst_pre got=%b want=1", out_valid); end
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_drop got=%b want=0", out_valid); end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    total++;
    if (out_ready !== 1'b1) begin bad++; $display("FAIL mrst_ready got=%b want=1", out_ready); end
    repeat (10) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (out_valid) stale++;
    end
    total++;
    if (stale != 0) begin bad++; $display("FAIL mrst_stale got=%0d want=0", stale); end
    @(negedge clk);
    drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      if (k == 3) begin
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_early got=%b want=0", out_valid); end
      end
      if (k == 4) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL mrst_noaccept got=0 want=1");
        end else begin
          e = q.pop_front();
          if (out_valid !== 1'b1 || obs !== e) begin
            bad++; $display("FAIL mrst_result got=v%b %h want=v1 %h", out_valid, obs, e);
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
